tpu_host_driver: RTL
====================

Name: tpu_host_driver

Overview:
- Host-side initiator for the 2x2 matrix-multiply controller's byte-serial load/readout interface.
- Accepts one packed job (A, B) on a valid/ready handshake, then serialises all eight operand bytes onto the load bus.
- Waits for the controller's done, reads back the four C bytes via output_sel, and returns the packed result on a valid/ready handshake.
- Sits between the system/bus side and the controller; shares its clk/rst.

Parameters:
- DATA_W, 8, element width; fixed at 8 to match the controller byte bus.
- TIMEOUT_CYCLES, 255, maximum WAIT_DONE cycles before the job aborts with res_timeout=1; range 1..65535.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- job_valid  input  1  job offered.
- job_ready  output  1  driver can accept a job; high only in IDLE.
- job_a  input  32  matrix A; element k={row,col} at bits [8k+7:8k].
- job_b  input  32  matrix B; same packing as job_a.
- res_valid  output  1  result available; held until accepted.
- res_ready  input  1  result consumer ready.
- res_c  output  32  matrix C; same packing as job_a.
- res_timeout  output  1  qualifies res_valid; 1 means done never arrived and res_c=0.
- busy  output  1  high in every state except IDLE.
- load_en_in  output  1  to controller: load strobe.
- load_sel_ab  output  1  to controller: 0 selects A, 1 selects B.
- load_index  output  2  to controller: {row,col}.
- in_data  output  8  to controller: operand byte.
- output_en  output  1  to controller: readout enable.
- output_sel  output  2  to controller: readout {row,col}.
- out_data  input  8  from controller: combinational C byte for output_sel.
- done  input  1  from controller: multiply complete.

Behaviour:
- All outputs are registered. Reset is synchronous: the state returns to IDLE and every output reads 0, except job_ready, which reads 1 on the first cycle after reset deasserts.
- States: IDLE, LOAD, WAIT_DONE, READ, RESP.
- IDLE:
  - job_ready=1.
  - When job_valid&job_ready, capture job_a/job_b, clear the result register and go to LOAD.
  - job_valid is ignored in every other state.
- LOAD:
  - Exactly 8 cycles with load_en_in=1.
  - Order: A k=0,1,2,3, then B k=0,1,2,3; in_data = byte k of the operand.
  - Then go to WAIT_DONE.
  - Job accepted at cycle T puts the beats on the bus in cycles T+1..T+8.
- WAIT_DONE:
  - load_en_in=0; a cycle counter starts at 0.
  - done sampled high -> go to READ.
  - Counter reaching TIMEOUT_CYCLES-1 without done -> go to RESP with res_timeout=1 and res_c=0.
  - done sampled in any other state is ignored.
- READ:
  - 4 cycles, k=0..3, with output_en=1 and output_sel=k.
  - out_data is captured into res_c byte k at the end of that cycle.
- RESP:
  - res_valid=1; res_c and res_timeout are held stable.
  - On res_valid&res_ready, go to IDLE next cycle (res_valid=0, job_ready=1).
- Latency: done sampled in cycle D gives res_valid in cycle D+5. Minimum job-accept to res_valid is 9 + (done delay) + 5 cycles.
- Back-to-back jobs: the next job can be accepted no earlier than the cycle after the result handshake. This ensures loads never coincide with the controller's done-cycle clearing of its load flags.
- Timeout does not reset the controller; recovery is system rst. After a timeout the driver returns to IDLE normally.
- Reset mid-operation (any state):
  - Driver goes to IDLE on the next edge and drops load_en_in/output_en immediately (registered 0).
  - Partial loads are discarded.
  - The controller is reset by the same rst.
- No arithmetic in this block. C width/truncation is defined by the multiply datapath; the driver passes bytes through unchanged.

Test Plan:
- Basic multiply, job_a=0x04030201, job_b=0x08070605, res_ready=1 -> 8 load beats in the specified order, then res_c=0x322B1613 and res_timeout=0.
- Result back-pressure, res_ready=0 for 10 cycles after res_valid -> res_valid and res_c held stable; job_ready=0 until the handshake; IDLE reached the cycle after res_ready=1.
- job_valid held high throughout a job with changing job_a -> only the first value loaded; second job accepted only after the result handshake; both results correct.
- Controller replaced by a stub with done tied 0, TIMEOUT_CYCLES=16 -> res_valid exactly 16 cycles after entering WAIT_DONE with res_timeout=1 and res_c=0; next job accepted normally.
- Stub pulses done during LOAD beat 3 and again 5 cycles after LOAD ends -> the early pulse is ignored; READ begins the cycle after the second pulse.
- rst asserted on LOAD beat 5 -> next cycle load_en_in=0, busy=0, job_ready=1. A fresh job then completes with the correct res_c.

Source files
------------

// File: rtl/tpu_host_driver.sv
// ---------------------------------------------------------------------------
// tpu_host_driver
// Host-side initiator for the 2x2 matrix-multiply controller. Takes one packed
// job (A, B) on a valid/ready handshake, streams the eight operand bytes onto
// the controller's byte-serial load bus, waits for done (bounded by a timeout),
// reads the four C bytes back through output_sel and presents the packed
// result on a valid/ready handshake.
//
// Ports
//   clk, rst                  system clock, synchronous active-high reset
//   job_valid/job_ready       job handshake (job_ready high only in IDLE)
//   job_a, job_b              packed operands, element k={row,col} at [8k+7:8k]
//   res_valid/res_ready       result handshake, res_valid held until accepted
//   res_c, res_timeout        packed result; res_timeout=1 means done never came
//   busy                      high whenever the driver is not IDLE
//   load_en_in, load_sel_ab,
//   load_index, in_data       controller load bus
//   output_en, output_sel     controller readout request
//   out_data                  controller readout byte (combinational)
//   done                      controller multiply complete
// ---------------------------------------------------------------------------
module tpu_host_driver #(
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [4*DATA_W-1:0]   job_a,
    input  logic [4*DATA_W-1:0]   job_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [4*DATA_W-1:0]   res_c,
    output logic                  res_timeout,
    output logic                  busy,
    output logic                  load_en_in,
    output logic                  load_sel_ab,
    output logic [1:0]            load_index,
    output logic [DATA_W-1:0]     in_data,
    output logic                  output_en,
    output logic [1:0]            output_sel,
    input  logic [DATA_W-1:0]     out_data,
    input  logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_READ = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam logic [15:0] LP_WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [8*DATA_W-1:0]  r_ops;          // {B, A}: beat k of the load is byte k
    logic [8*DATA_W-1:0]  w_ops_nxt;
    logic [2:0]           r_beat;         // load beat (0..7) or readout index (0..3)
    logic [2:0]           w_beat_nxt;
    logic [15:0]          r_wait_cnt;
    logic [15:0]          w_wait_cnt_nxt;
    logic [4*DATA_W-1:0]  r_res;
    logic [4*DATA_W-1:0]  w_res_nxt;
    logic                 r_timeout;
    logic                 w_timeout_nxt;
    logic                 w_accept;

    logic                 r_job_ready,  w_job_ready_nxt;
    logic                 r_busy,       w_busy_nxt;
    logic                 r_res_valid,  w_res_valid_nxt;
    logic                 r_load_en,    w_load_en_nxt;
    logic                 r_load_sel,   w_load_sel_nxt;
    logic [1:0]           r_load_idx,   w_load_idx_nxt;
    logic [DATA_W-1:0]    r_in_data,    w_in_data_nxt;
    logic                 r_out_en,     w_out_en_nxt;
    logic [1:0]           r_out_sel,    w_out_sel_nxt;

    assign w_accept = (r_state == S_IDLE) && job_valid && r_job_ready;

    // State register plus every registered output and datapath register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ops       <= '0;
            r_beat      <= 3'd0;
            r_wait_cnt  <= 16'd0;
            r_res       <= '0;
            r_timeout   <= 1'b0;
            r_job_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_load_en   <= 1'b0;
            r_load_sel  <= 1'b0;
            r_load_idx  <= 2'd0;
            r_in_data   <= '0;
            r_out_en    <= 1'b0;
            r_out_sel   <= 2'd0;
        end else begin
            r_state     <= w_next_state;
            r_ops       <= w_ops_nxt;
            r_beat      <= w_beat_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_res       <= w_res_nxt;
            r_timeout   <= w_timeout_nxt;
            r_job_ready <= w_job_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_load_en   <= w_load_en_nxt;
            r_load_sel  <= w_load_sel_nxt;
            r_load_idx  <= w_load_idx_nxt;
            r_in_data   <= w_in_data_nxt;
            r_out_en    <= w_out_en_nxt;
            r_out_sel   <= w_out_sel_nxt;
        end
    end

    // Next-state decision
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = S_LOAD;
                else          w_next_state = S_IDLE;
            end
            S_LOAD: begin
                if (r_beat == 3'd7) w_next_state = S_WAIT;
                else                w_next_state = S_LOAD;
            end
            S_WAIT: begin
                // done on the last allowed cycle still wins over the timeout
                if (done)                            w_next_state = S_READ;
                else if (r_wait_cnt == LP_WAIT_LAST) w_next_state = S_RESP;
                else                                 w_next_state = S_WAIT;
            end
            S_READ: begin
                if (r_beat[1:0] == 2'd3) w_next_state = S_READ == S_READ ? S_RESP : S_READ;
                else                     w_next_state = S_READ;
            end
            S_RESP: begin
                if (res_ready) w_next_state = S_IDLE;
                else           w_next_state = S_RESP;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Next values of outputs and datapath; outputs are driven from the upcoming
    // state so that they line up with it after the clock edge
    always_comb begin
        w_ops_nxt     = r_ops;
        w_res_nxt     = r_res;
        w_timeout_nxt = r_timeout;

        if (w_accept) begin
            w_ops_nxt     = {job_b, job_a};
            w_res_nxt     = '0;
            w_timeout_nxt = 1'b0;
        end else if (r_state == S_READ) begin
            // readout byte k lands in result byte k (byte width fixed at 8)
            w_res_nxt[{r_beat[1:0], 3'b000} +: DATA_W] = out_data;
        end else if ((r_state == S_WAIT) && (w_next_state == S_RESP)) begin
            w_timeout_nxt = 1'b1;
        end else begin
            w_timeout_nxt = r_timeout;
        end

        // beat index restarts at 0 on every entry into LOAD or READ
        if ((w_next_state == r_state) && ((r_state == S_LOAD) || (r_state == S_READ))) begin
            w_beat_nxt = r_beat + 3'd1;
        end else begin
            w_beat_nxt = 3'd0;
        end

        if ((r_state == S_WAIT) && (w_next_state == S_WAIT)) begin
            w_wait_cnt_nxt = r_wait_cnt + 16'd1;
        end else begin
            w_wait_cnt_nxt = 16'd0;
        end

        w_job_ready_nxt = (w_next_state == S_IDLE);
        w_busy_nxt      = (w_next_state != S_IDLE);
        w_res_valid_nxt = (w_next_state == S_RESP);
        w_load_en_nxt   = (w_next_state == S_LOAD);
        w_out_en_nxt    = (w_next_state == S_READ);

        if (w_load_en_nxt) begin
            w_load_sel_nxt = w_beat_nxt[2];
            w_load_idx_nxt = w_beat_nxt[1:0];
            w_in_data_nxt  = w_ops_nxt[{w_beat_nxt, 3'b000} +: DATA_W];
        end else begin
            w_load_sel_nxt = 1'b0;
            w_load_idx_nxt = 2'd0;
            w_in_data_nxt  = '0;
        end

        if (w_out_en_nxt) begin
            w_out_sel_nxt = w_beat_nxt[1:0];
        end else begin
            w_out_sel_nxt = 2'd0;
        end
    end

    assign job_ready   = r_job_ready;
    assign busy        = r_busy;
    assign res_valid   = r_res_valid;
    assign res_c       = r_res;
    assign res_timeout = r_timeout;
    assign load_en_in  = r_load_en;
    assign load_sel_ab = r_load_sel;
    assign load_index  = r_load_idx;
    assign in_data     = r_in_data;
    assign output_en   = r_out_en;
    assign output_sel  = r_out_sel;

endmodule
